// File: rtl/branch_resolver.sv
// In-order branch resolution queue for a gshare predictor: issues one registered
// counter-update per resolved branch, flags mispredictions and keeps saturating stats.
module branch_resolver #(
    parameter int PATTERN_WIDTH = 4,
    parameter int PC_BITS       = 8,
    parameter int DEPTH         = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pred_valid,
    input  logic [PC_BITS-1:0]       pred_pc,
    input  logic                     pred_taken,
    input  logic [PATTERN_WIDTH-1:0] pred_pattern,
    output logic                     queue_full,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_en,
    output logic [PC_BITS-1:0]       upd_pc,
    output logic [PATTERN_WIDTH-1:0] upd_pattern,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic [PATTERN_WIDTH-1:0] repair_pattern,
    output logic                     underflow,
    output logic [CNT_WIDTH-1:0]     branch_cnt,
    output logic [CNT_WIDTH-1:0]     miss_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]         count_q, count_d;
    logic [PC_BITS-1:0]       pc_mem_q    [DEPTH];
    logic                     taken_mem_q [DEPTH];
    logic [PATTERN_WIDTH-1:0] pat_mem_q   [DEPTH];
    logic                     pop, push, miss;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic inc);
        if (inc && (v != '1)) return v + CNT_WIDTH'(1);
        return v;
    endfunction

    assign queue_full = (count_q == OCC_W'(DEPTH));
    assign pop        = res_valid && (count_q != '0);
    assign miss       = pop && (taken_mem_q[rd_ptr_q] != res_taken);
    // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside it.
    assign push       = pred_valid && (!queue_full || pop) && !miss;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (miss) begin
            // Everything still queued is younger wrong-path work.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= pred_pc;
            taken_mem_q[wr_ptr_q] <= pred_taken;
            pat_mem_q[wr_ptr_q]   <= pred_pattern;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            upd_en         <= 1'b0;
            upd_pc         <= '0;
            upd_pattern    <= '0;
            upd_taken      <= 1'b0;
            mispredict     <= 1'b0;
            repair_pattern <= '0;
            underflow      <= 1'b0;
            branch_cnt     <= '0;
            miss_cnt       <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            upd_en     <= pop;
            mispredict <= miss;
            if (pop) begin
                upd_pc         <= pc_mem_q[rd_ptr_q];
                upd_pattern    <= pat_mem_q[rd_ptr_q];
                upd_taken      <= res_taken;
                repair_pattern <= {res_taken, pat_mem_q[rd_ptr_q][PATTERN_WIDTH-1:1]};
            end
            if (res_valid && (count_q == '0)) underflow <= 1'b1;
            branch_cnt <= sat_inc(branch_cnt, pop);
            miss_cnt   <= sat_inc(miss_cnt, miss);
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vector table, hand sequences and random traffic
// checked against a queue-based model; a second instance with 2-bit counters checks saturation.
module tb_branch_resolver;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, pred_valid, pred_taken, res_valid, res_taken;
    logic [7:0] pred_pc;
    logic [3:0] pred_pattern;

    logic        queue_full, upd_en, upd_taken, mispredict, underflow;
    logic [7:0]  upd_pc;
    logic [3:0]  upd_pattern, repair_pattern;
    logic [15:0] branch_cnt, miss_cnt;

    logic        s_queue_full, s_upd_en, s_upd_taken, s_mispredict, s_underflow;
    logic [7:0]  s_upd_pc;
    logic [3:0]  s_upd_pattern, s_repair_pattern;
    logic [1:0]  s_branch_cnt, s_miss_cnt;

    always #5 clk = ~clk;

    branch_resolver u_dut (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_pattern(pred_pattern), .queue_full(queue_full),
        .res_valid(res_valid), .res_taken(res_taken), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_pattern(upd_pattern), .upd_taken(upd_taken), .mispredict(mispredict),
        .repair_pattern(repair_pattern), .underflow(underflow), .branch_cnt(branch_cnt),
        .miss_cnt(miss_cnt)
    );

    branch_resolver #(.CNT_WIDTH(2)) u_small (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_pattern(pred_pattern), .queue_full(s_queue_full),
        .res_valid(res_valid), .res_taken(res_taken), .upd_en(s_upd_en), .upd_pc(s_upd_pc),
        .upd_pattern(s_upd_pattern), .upd_taken(s_upd_taken), .mispredict(s_mispredict),
        .repair_pattern(s_repair_pattern), .underflow(s_underflow), .branch_cnt(s_branch_cnt),
        .miss_cnt(s_miss_cnt)
    );

    typedef struct {
        logic [7:0] pc;
        logic       taken;
        logic [3:0] pat;
    } entry_t;

    entry_t q[$];
    int     m_bc, m_mc;
    logic   m_en, m_tk, m_mis, m_uf;
    logic [7:0] m_pc;
    logic [3:0] m_pat, m_rep;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic step(input logic rst, input logic pv, input logic [7:0] pc, input logic pt,
                        input logic [3:0] pp, input logic rv, input logic rt);
        entry_t e;
        int     sz;
        logic   popped, mis;
        reset = rst; pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_pattern = pp;
        res_valid = rv; res_taken = rt;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_en = 0; m_pc = 0; m_pat = 0; m_tk = 0; m_mis = 0; m_rep = 0; m_uf = 0;
            m_bc = 0; m_mc = 0;
        end else begin
            sz = q.size(); popped = 0; mis = 0;
            m_en = 0; m_mis = 0;
            if (rv) begin
                if (sz == 0) m_uf = 1;
                else begin
                    e = q.pop_front();
                    popped = 1;
                    m_en = 1; m_pc = e.pc; m_pat = e.pat; m_tk = rt;
                    mis = (e.taken != rt);
                    m_mis = mis;
                    m_rep = {rt, e.pat[3:1]};
                    m_bc++;
                    if (mis) m_mc++;
                end
            end
            if (mis) q.delete();
            else if (pv && (sz < DEPTH || popped)) q.push_back('{pc, pt, pp});
        end
        #1;
        chk("queue_full", 32'(queue_full), 32'(q.size() == DEPTH));
        chk("upd_en", 32'(upd_en), 32'(m_en));
        chk("upd_pc", 32'(upd_pc), 32'(m_pc));
        chk("upd_pattern", 32'(upd_pattern), 32'(m_pat));
        chk("upd_taken", 32'(upd_taken), 32'(m_tk));
        chk("mispredict", 32'(mispredict), 32'(m_mis));
        chk("repair_pattern", 32'(repair_pattern), 32'(m_rep));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("branch_cnt", 32'(branch_cnt), 32'(sat(m_bc, 65535)));
        chk("miss_cnt", 32'(miss_cnt), 32'(sat(m_mc, 65535)));
        chk("small_upd_en", 32'(s_upd_en), 32'(m_en));
        chk("small_branch_cnt", 32'(s_branch_cnt), 32'(sat(m_bc, 3)));
        chk("small_miss_cnt", 32'(s_miss_cnt), 32'(sat(m_mc, 3)));
    endtask

    typedef struct {
        logic       pv;
        logic [7:0] pc;
        logic       pt;
        logic       rv;
        logic       rt;
        logic       e_en;
        logic [7:0] e_pc;
        logic       e_mis;
        logic       e_full;
        int         e_bc;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // in-order resolve of three correctly predicted branches
        tbl.push_back('{1, 8'h10, 1, 0, 0, 0, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 8'h11, 0, 0, 0, 0, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 8'h12, 1, 0, 0, 0, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 1, 1, 8'h10, 0, 0, 1});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 1, 8'h11, 0, 0, 2});
        tbl.push_back('{0, 8'h00, 0, 1, 1, 1, 8'h12, 0, 0, 3});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 0, 8'h12, 0, 0, 3});
        // fill, dropped push when full, push+pop when full, then drain
        tbl.push_back('{1, 8'h30, 0, 0, 0, 0, 8'h12, 0, 0, 3});
        tbl.push_back('{1, 8'h31, 0, 0, 0, 0, 8'h12, 0, 0, 3});
        tbl.push_back('{1, 8'h32, 0, 0, 0, 0, 8'h12, 0, 0, 3});
        tbl.push_back('{1, 8'h33, 0, 0, 0, 0, 8'h12, 0, 1, 3});
        tbl.push_back('{1, 8'h34, 0, 0, 0, 0, 8'h12, 0, 1, 3});
        tbl.push_back('{1, 8'h35, 0, 1, 0, 1, 8'h30, 0, 1, 4});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 1, 8'h31, 0, 0, 5});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 1, 8'h32, 0, 0, 6});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 1, 8'h33, 0, 0, 7});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 1, 8'h35, 0, 0, 8});

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_full", 32'(queue_full), 0);
        chk("reset_cnt", 32'(branch_cnt), 0);

        foreach (tbl[i]) begin
            step(0, tbl[i].pv, tbl[i].pc, tbl[i].pt, 4'h3, tbl[i].rv, tbl[i].rt);
            chk("tbl_upd_en", 32'(upd_en), 32'(tbl[i].e_en));
            chk("tbl_upd_pc", 32'(upd_pc), 32'(tbl[i].e_pc));
            chk("tbl_mispredict", 32'(mispredict), 32'(tbl[i].e_mis));
            chk("tbl_queue_full", 32'(queue_full), 32'(tbl[i].e_full));
            chk("tbl_branch_cnt", 32'(branch_cnt), 32'(tbl[i].e_bc));
            chk("tbl_miss_cnt", 32'(miss_cnt), 0);
        end

        // mispredict flushes the younger entries
        step(0, 1, 8'h20, 1, 4'b1010, 0, 0);
        step(0, 1, 8'h21, 0, 4'b0001, 0, 0);
        step(0, 1, 8'h22, 0, 4'b0010, 0, 0);
        step(0, 1, 8'h23, 1, 4'b0011, 1, 0);
        chk("flush_mispredict", 32'(mispredict), 1);
        chk("flush_repair", 32'(repair_pattern), 32'(4'b0101));
        chk("flush_upd_taken", 32'(upd_taken), 0);
        chk("flush_upd_pc", 32'(upd_pc), 32'h20);
        chk("flush_full", 32'(queue_full), 0);
        chk("flush_miss_cnt", 32'(miss_cnt), 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("mispredict_pulse", 32'(mispredict), 0);

        // resolve on empty queue: underflow sticks through normal traffic
        step(0, 0, 0, 0, 0, 1, 1);
        chk("uf_upd_en", 32'(upd_en), 0);
        chk("uf_set", 32'(underflow), 1);
        step(0, 1, 8'h40, 1, 4'h5, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("uf_normal_upd", 32'(upd_en), 1);
        chk("uf_sticky", 32'(underflow), 1);

        // reset mid-stream with two queued entries and a resolve pending
        step(0, 1, 8'h41, 1, 4'h6, 0, 0);
        step(0, 1, 8'h42, 1, 4'h7, 0, 0);
        step(1, 1, 8'h43, 1, 4'h8, 1, 1);
        chk("rst_upd_en", 32'(upd_en), 0);
        chk("rst_upd_pc", 32'(upd_pc), 0);
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_branch_cnt", 32'(branch_cnt), 0);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("rst_empty_upd", 32'(upd_en), 0);
        chk("rst_empty_uf", 32'(underflow), 1);

        // five mispredicts: 2-bit counters pin at 3
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'(8'h50 + i), 1, 4'(i), 0, 0);
            step(0, 0, 0, 0, 0, 1, 0);
        end
        chk("sat_small_branch", 32'(s_branch_cnt), 3);
        chk("sat_small_miss", 32'(s_miss_cnt), 3);
        chk("sat_wide_branch", 32'(branch_cnt), 5);
        chk("sat_wide_miss", 32'(miss_cnt), 5);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 99) < 60, 8'($urandom),
                 1'($urandom), 4'($urandom), $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 85 ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
